// File: rtl/add_pipe_if.sv
// Handshake bundle for add_pipe: operand/carry-in side and result side.
interface add_pipe_if #(
    parameter int unsigned WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             Ci;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] S;
    logic             Co;
    logic             Ov;

    // Producer/consumer side (drives operands, accepts results)
    modport master (
        output in_valid, A, B, Ci, out_ready,
        input  in_ready, out_valid, S, Co, Ov
    );

    // Adder side
    modport slave (
        input  in_valid, A, B, Ci, out_ready,
        output in_ready, out_valid, S, Co, Ov
    );
endinterface

// File: rtl/add_pipe.sv
// Pipelined ripple-carry adder: one CHUNK-bit slice resolved per stage, carry
// registered between stages, unconsumed operand slices shifted down with the token.
module add_pipe #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned CHUNK = 4
) (
    input  logic      clk,
    input  logic      rst_n,
    add_pipe_if.slave bus
);
    localparam int unsigned CHUNK_SAFE = (CHUNK < 1) ? 1 : CHUNK;
    localparam int unsigned STAGES     = ((WIDTH / CHUNK_SAFE) < 1) ? 1 : (WIDTH / CHUNK_SAFE);

    // Reject chunkings that do not tile the operand exactly
    if ((CHUNK < 1) || ((WIDTH % CHUNK_SAFE) != 0)) begin : g_bad_params
        $error("add_pipe: WIDTH must be a non-zero multiple of CHUNK");
    end

    // Per-stage token state; a_q/b_q hold the not-yet-consumed upper slices, LSB-aligned
    logic [STAGES-1:0] valid_q, valid_d;
    logic [STAGES-1:0] c_q, c_d;
    logic [WIDTH-1:0]  a_q [STAGES];
    logic [WIDTH-1:0]  a_d [STAGES];
    logic [WIDTH-1:0]  b_q [STAGES];
    logic [WIDTH-1:0]  b_d [STAGES];
    logic [WIDTH-1:0]  s_q [STAGES];
    logic [WIDTH-1:0]  s_d [STAGES];
    logic              ov_q, ov_d;

    // What each stage sees as its upstream: the input port for stage 0, else the previous stage
    logic [STAGES-1:0] src_v;
    logic [STAGES-1:0] src_c;
    logic [WIDTH-1:0]  src_a [STAGES];
    logic [WIDTH-1:0]  src_b [STAGES];
    logic [WIDTH-1:0]  src_s [STAGES];
    logic [CHUNK:0]    slice_sum;
    logic              stall;

    // A result sitting at the output that nobody takes freezes the whole pipe
    assign stall        = valid_q[STAGES-1] & ~bus.out_ready;
    assign bus.in_ready = ~stall;

    // Stage advance: ripple one slice per stage, accumulate sum bits, shift operands down
    always_comb begin
        valid_d   = valid_q;
        c_d       = c_q;
        a_d       = a_q;
        b_d       = b_q;
        s_d       = s_q;
        ov_d      = ov_q;
        slice_sum = '0;
        src_v     = '0;
        src_c     = '0;
        src_a     = '{default: '0};
        src_b     = '{default: '0};
        src_s     = '{default: '0};

        src_v[0] = bus.in_valid;
        src_c[0] = bus.Ci;
        src_a[0] = bus.A;
        src_b[0] = bus.B;
        src_s[0] = '0;
        for (int unsigned k = 1; k < STAGES; k++) begin
            src_v[k] = valid_q[k-1];
            src_c[k] = c_q[k-1];
            src_a[k] = a_q[k-1];
            src_b[k] = b_q[k-1];
            src_s[k] = s_q[k-1];
        end

        if (!stall) begin
            for (int unsigned k = 0; k < STAGES; k++) begin
                slice_sum  = (CHUNK+1)'(src_a[k][CHUNK-1:0])
                           + (CHUNK+1)'(src_b[k][CHUNK-1:0])
                           + (CHUNK+1)'(src_c[k]);
                valid_d[k] = src_v[k];
                c_d[k]     = slice_sum[CHUNK];
                a_d[k]     = src_a[k] >> CHUNK;
                b_d[k]     = src_b[k] >> CHUNK;
                s_d[k]     = src_s[k] | (WIDTH'(slice_sum[CHUNK-1:0]) << (k * CHUNK));
                // The last stage's slice carries the operand MSBs
                if (k == STAGES - 1) begin
                    ov_d = (src_a[k][CHUNK-1] == src_b[k][CHUNK-1])
                        && (slice_sum[CHUNK-1] != src_a[k][CHUNK-1]);
                end
            end
        end
    end

    // Pipeline registers, cleared asynchronously so in-flight tokens are dropped
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            c_q     <= '0;
            ov_q    <= 1'b0;
            for (int unsigned k = 0; k < STAGES; k++) begin
                a_q[k] <= '0;
                b_q[k] <= '0;
                s_q[k] <= '0;
            end
        end else begin
            valid_q <= valid_d;
            c_q     <= c_d;
            ov_q    <= ov_d;
            a_q     <= a_d;
            b_q     <= b_d;
            s_q     <= s_d;
        end
    end

    // Results come straight from the last stage's registers
    assign bus.out_valid = valid_q[STAGES-1];
    assign bus.S         = s_q[STAGES-1];
    assign bus.Co        = c_q[STAGES-1];
    assign bus.Ov        = ov_q;
endmodule
